// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory port arbiter: FSM states,
// requester IDs and the response-timeout counter sizing.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    localparam logic PORT_IF   = 1'b0;
    localparam logic PORT_DATA = 1'b1;

    localparam int unsigned DEFAULT_TIMEOUT = 15;
    localparam int unsigned CNT_W           = 8;

endpackage

// File: rtl/memarb_timer.sv
// Clearable saturating response-timeout counter; expired flags the last
// BUSY cycle allowed before an abort (count == TIMEOUT-1).
module memarb_timer
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port (fetch/data) arbiter and sequencer for the shared memory port.
// Define MEMARB_ROUND_ROBIN_EN for round-robin ties; default is data-port priority.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REQ0,
    input  logic [31:0] ADDR0,
    input  logic        REQ1,
    input  logic [31:0] ADDR1,
    input  logic        WE1,
    input  logic [31:0] WDATA1,
    output logic        SEL,
    output logic        MEM_REQ,
    output logic        MEM_WE,
    output logic [31:0] MEM_ADDR,
    output logic [31:0] MEM_WDATA,
    input  logic        MEM_RDY,
    input  logic [31:0] MEM_RDATA,
    output logic [31:0] RDATA,
    output logic        DONE0,
    output logic        DONE1,
    output logic        ERR
);

    state_t state;
    logic   grant;
    logic   winner;
    logic   expired;
`ifdef MEMARB_ROUND_ROBIN_EN
    logic   last;
`endif

    assign grant = (state == IDLE) && (REQ0 || REQ1);

    always_comb begin
        winner = REQ1 ? PORT_DATA : PORT_IF;
`ifdef MEMARB_ROUND_ROBIN_EN
        if (REQ0 && REQ1) winner = ~last;
`endif
    end

    memarb_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk    (CLK),
        .rst    (RST),
        .clr    (grant),
        .en     (state == BUSY),
        .expired(expired)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            SEL       <= PORT_IF;
            MEM_REQ   <= 1'b0;
            MEM_WE    <= 1'b0;
            MEM_ADDR  <= '0;
            MEM_WDATA <= '0;
            RDATA     <= '0;
            DONE0     <= 1'b0;
            DONE1     <= 1'b0;
            ERR       <= 1'b0;
`ifdef MEMARB_ROUND_ROBIN_EN
            last      <= PORT_DATA;
`endif
        end else begin
            // completion pulses and ERR are only ever high in RESP
            DONE0 <= 1'b0;
            DONE1 <= 1'b0;
            ERR   <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant) begin
                        SEL       <= winner;
                        MEM_ADDR  <= (winner == PORT_DATA) ? ADDR1 : ADDR0;
                        MEM_WE    <= (winner == PORT_DATA) && WE1;
                        MEM_WDATA <= WDATA1;
                        MEM_REQ   <= 1'b1;
                        state     <= BUSY;
`ifdef MEMARB_ROUND_ROBIN_EN
                        last      <= winner;
`endif
                    end
                end
                BUSY: begin
                    if (MEM_RDY || expired) begin
                        RDATA   <= (MEM_RDY && !MEM_WE) ? MEM_RDATA : '0;
                        ERR     <= !MEM_RDY;
                        DONE0   <= (SEL == PORT_IF);
                        DONE1   <= (SEL == PORT_DATA);
                        MEM_REQ <= 1'b0;
                        state   <= RESP;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer for the single shared 32-bit memory port of the MIPS core. It accepts requests from instruction fetch (port 0) and data access (port 1), grants one at a time, and drives the `SEL` line of the downstream 32-bit 2:1 address mux. It runs a request/ready handshake with memory, enforces a response timeout, and returns read data with a one-cycle completion pulse to the winning requester.

## Interface
Parameters:
- `TIMEOUT`, default 15: maximum cycles in BUSY without `MEM_RDY` before the transaction is aborted with an error. Legal range 1..255.

Ports:
- `CLK`  in  1: single clock, rising edge.
- `RST`  in  1: asynchronous, active-high reset.
- `REQ0`  in  1: fetch request; held high until `DONE0`.
- `ADDR0`  in  32: fetch address; read-only port.
- `REQ1`  in  1: data request; held high until `DONE1`.
- `ADDR1`  in  32: data address.
- `WE1`  in  1: data write enable.
- `WDATA1`  in  32: data write value.
- `SEL`  out  1: registered owner, 0 = port 0, 1 = port 1; drives the address/data mux select.
- `MEM_REQ`  out  1: memory request strobe.
- `MEM_WE`  out  1: memory write enable; always 0 for port 0.
- `MEM_ADDR`  out  32: registered address.
- `MEM_WDATA`  out  32: registered write data.
- `MEM_RDY`  in  1: memory completion.
- `MEM_RDATA`  in  32: memory read data, valid with `MEM_RDY`.
- `RDATA`  out  32: registered read data to both requesters.
- `DONE0`, `DONE1`  out  1 each: one-cycle completion pulses.
- `ERR`  out  1: timeout flag, valid with `DONEx`.

## Operation
- States: IDLE, BUSY, RESP.
- **IDLE:** with no request, stay in IDLE. When any `REQx` is high, pick a winner and register the following at the edge, then go to BUSY:
  - `SEL` = winner.
  - `MEM_ADDR` = `ADDRx`.
  - `MEM_WE` = `WE1` if the winner is port 1, else 0.
  - `MEM_WDATA` = `WDATA1`.
  - `MEM_REQ` = 1.
- **Arbitration:** a single request wins outright. On a tie, port 1 wins (see Configuration).
- **BUSY:**
  - `MEM_REQ` is held at 1 and the timeout counter increments each cycle.
  - If `MEM_RDY` = 1: `RDATA` ← `MEM_RDATA` (0 for writes), `DONE[SEL]` ← 1, `ERR` ← 0, `MEM_REQ` ← 0, go to RESP.
  - Else if the counter equals `TIMEOUT`-1: `RDATA` ← 0, `DONE[SEL]` ← 1, `ERR` ← 1, `MEM_REQ` ← 0, go to RESP.
- **RESP:** lasts exactly one cycle. `DONEx` and `ERR` are high here only. `REQx` is ignored in this cycle; the requester drops or renews `REQ` during it. Then go to IDLE.
- `SEL` holds its last value in IDLE and RESP. It changes only on a grant.
- `MEM_RDY` is ignored outside BUSY.
- The counter clears on entry to BUSY and saturates. It is 8 bits wide.

## Timing
- Reset (async, immediate) drives every output to 0: `SEL`, `MEM_REQ`, `MEM_WE`, `MEM_ADDR`, `MEM_WDATA`, `RDATA`, `DONE0`, `DONE1`, `ERR`. The state goes to IDLE and the counter to 0.
- Reset asserted mid-transaction abandons the transaction without a `DONE` pulse.
- Latency with zero-wait memory (`MEM_RDY` high in the first BUSY cycle):
  - `REQ` sampled at edge N.
  - `MEM_REQ` high in cycle N+1.
  - `DONE` high in cycle N+2.
  - Next grant at edge N+3.
- Minimum 3 cycles per transaction. Each memory wait cycle adds 1.
- A timeout gives `DONE`/`ERR` exactly `TIMEOUT`+1 cycles after the grant edge.
- `MEM_ADDR`, `MEM_WE` and `MEM_WDATA` stay stable from the grant edge until the next grant.

## Configuration
- `MEMARB_ROUND_ROBIN_EN`:
  - **Defined:** a `LAST` register records the last served port. It resets to 1, so port 0 wins the first tie. On a tie, the port not equal to `LAST` wins. `LAST` updates on every grant.
  - **Undefined:** fixed priority, with port 1 (data) always winning ties. No `LAST` register is built.

## Structure
- Package `mem_port_arbiter_pkg` holds:
  - the state enum (IDLE/BUSY/RESP);
  - port ID constants `PORT_IF` = 0 and `PORT_DATA` = 1;
  - the default `TIMEOUT` and the counter width (8).
- One sub-module, `memarb_timer`: a clearable saturating 8-bit counter with an `expired` compare output against `TIMEOUT`-1.

## Test plan
- **Reset:** assert `RST` mid-BUSY → all outputs are 0 in the same cycle, no `DONE` pulse, and the next `REQ0` is served normally.
- **Single fetch:** `REQ0` = 1, `ADDR0` = 0x0040_0000, `MEM_RDY` high in the first BUSY cycle, `MEM_RDATA` = 0x2008_0005 → `SEL` = 0, `MEM_ADDR` = 0x0040_0000, `DONE0` exactly two cycles after grant, `RDATA` = 0x2008_0005, `ERR` = 0.
- **Data write with 3 wait cycles:** `REQ1` = 1, `WE1` = 1, `ADDR1` = 0x1001_0004, `WDATA1` = 0xDEAD_BEEF → `MEM_WE` = 1 and `MEM_WDATA` = 0xDEAD_BEEF held for 4 cycles, then `DONE1` pulse, `RDATA` = 0.
- **Tie, no macro:** `REQ0` and `REQ1` both held high → order 1, 1, 1…; port 0 is served only after `REQ1` drops.
- **Tie with `MEMARB_ROUND_ROBIN_EN`:** both held high for 4 transactions → grant order 0, 1, 0, 1 with `SEL` toggling.
- **Timeout:** `TIMEOUT` = 4, `REQ0` = 1, `MEM_RDY` held 0 → `DONE0` = 1, `ERR` = 1, `RDATA` = 0, 5 cycles after grant; `MEM_REQ` low in the RESP cycle.
